// File: rtl/expand_a_pkg.sv
// Shared types and constants for the ExpandA streaming generator and its FIFO.
package expand_a_pkg;

    localparam int unsigned N       = 256;
    localparam int unsigned COEFF_W = 23;
    localparam logic [COEFF_W-1:0] Q = 23'd8380417;
    localparam int unsigned KMAX    = 8;
    localparam int unsigned LMAX    = 7;
    localparam int unsigned ROW_W   = $clog2(KMAX);
    localparam int unsigned COL_W   = $clog2(LMAX);
    localparam int unsigned SEED_W  = 272;

    typedef enum logic [1:0] {
        ModeK4L4    = 2'd0,
        ModeK6L5    = 2'd1,
        ModeK8L7    = 2'd2,
        ModeInvalid = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StRun    = 2'd2,
        StDrain  = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] k;
        logic [3:0] l;
    } dims_t;

    typedef struct packed {
        logic [COEFF_W-1:0] coeff;
        logic [ROW_W-1:0]   row;
        logic [COL_W-1:0]   col;
        logic [7:0]         idx;
    } fifo_entry_t;

    // Grid size for a mode; the invalid mode falls back to 4x4 and is rejected by the caller.
    function automatic dims_t mode_dims(input mode_e mode);
        dims_t d;
        d.k = 4'd4;
        d.l = 4'd4;
        case (mode)
            ModeK6L5: begin
                d.k = 4'd6;
                d.l = 4'd5;
            end
            ModeK8L7: begin
                d.k = 4'd8;
                d.l = 4'd7;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/expand_a_stream_if.sv
// Sampler handshake plus tagged output stream of the ExpandA generator.
interface expand_a_stream_if;
    import expand_a_pkg::*;

    logic                samp_start;
    logic                samp_abort;
    logic [SEED_W-1:0]   samp_seed;
    logic                samp_valid;
    logic [COEFF_W-1:0]  samp_coeff;
    logic                samp_ready;

    logic                out_valid;
    logic                out_ready;
    logic [COEFF_W-1:0]  out_coeff;
    logic [ROW_W-1:0]    out_row;
    logic [COL_W-1:0]    out_col;
    logic [7:0]          out_idx;
    logic                out_last;

    modport master (
        output samp_start, samp_abort, samp_seed, samp_ready,
        output out_valid, out_coeff, out_row, out_col, out_idx, out_last,
        input  samp_valid, samp_coeff, out_ready
    );

    modport slave (
        input  samp_start, samp_abort, samp_seed, samp_ready,
        input  out_valid, out_coeff, out_row, out_col, out_idx, out_last,
        output samp_valid, samp_coeff, out_ready
    );

endinterface

// File: rtl/expand_a_fifo.sv
// Small synchronous FIFO of tagged coefficients with flush; DEPTH must be a power of two.
module expand_a_fifo
    import expand_a_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_push,
    input  fifo_entry_t i_data,
    input  logic        i_pop,
    output fifo_entry_t o_data,
    output logic        o_full,
    output logic        o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    fifo_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/expand_a_stream.sv
// Walks the K x L grid of matrix A, sequences the shared rejection sampler and streams
// its coefficients out tagged with (row, col, idx).
module expand_a_stream
    import expand_a_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [1:0]        i_mode,
    input  logic [255:0]      i_rho,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    expand_a_stream_if.master bus
);
    state_e            r_state, w_state_d;
    logic [255:0]      r_rho, w_rho_d;
    logic [ROW_W-1:0]  r_row, w_row_d, r_row_max, w_row_max_d;
    logic [COL_W-1:0]  r_col, w_col_d, r_col_max, w_col_max_d;
    logic [7:0]        r_idx, w_idx_d;
    logic [SEED_W-1:0] r_seed, w_seed_d;
    logic              r_err, w_err_d;
    logic              r_done, w_done_d;
    logic              r_samp_abort;
    logic              w_full, w_empty, w_push, w_pop;
    fifo_entry_t       w_wr_entry, w_head;
    dims_t             w_dims;

    assign w_dims          = mode_dims(mode_e'(i_mode));
    assign bus.samp_ready  = !w_full && (r_state == StRun);
    assign w_push          = bus.samp_valid && bus.samp_ready;
    assign w_pop           = bus.out_valid && bus.out_ready;
    assign bus.samp_start  = (r_state == StLaunch);
    assign bus.samp_abort  = r_samp_abort;
    assign bus.samp_seed   = r_seed;
    assign o_busy          = (r_state != StIdle);
    assign o_done          = r_done;
    assign o_err           = r_err;

    assign w_wr_entry.coeff = bus.samp_coeff;
    assign w_wr_entry.row   = r_row;
    assign w_wr_entry.col   = r_col;
    assign w_wr_entry.idx   = r_idx;

    always_comb begin
        w_state_d   = r_state;
        w_rho_d     = r_rho;
        w_row_d     = r_row;
        w_col_d     = r_col;
        w_row_max_d = r_row_max;
        w_col_max_d = r_col_max;
        w_idx_d     = r_idx;
        w_seed_d    = r_seed;
        w_err_d     = r_err;
        w_done_d    = 1'b0;
        if (i_abort) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        if (mode_e'(i_mode) == ModeInvalid) begin
                            w_err_d = 1'b1;
                        end else begin
                            w_rho_d     = i_rho;
                            w_row_max_d = ROW_W'(w_dims.k - 4'd1);
                            w_col_max_d = COL_W'(w_dims.l - 4'd1);
                            w_row_d     = '0;
                            w_col_d     = '0;
                            w_err_d     = 1'b0;
                            w_state_d   = StLaunch;
                        end
                    end
                end
                StLaunch: begin
                    w_idx_d   = '0;
                    w_state_d = StRun;
                end
                StRun: begin
                    if (w_push) begin
                        w_idx_d = r_idx + 8'd1;
                        if (bus.samp_coeff >= Q) begin
                            w_err_d = 1'b1;
                        end
                        // Row-major walk: the column is the inner loop.
                        if (r_idx == 8'hFF) begin
                            if (r_col != r_col_max) begin
                                w_col_d   = r_col + 1'b1;
                                w_state_d = StLaunch;
                            end else if (r_row != r_row_max) begin
                                w_row_d   = r_row + 1'b1;
                                w_col_d   = '0;
                                w_state_d = StLaunch;
                            end else begin
                                w_state_d = StDrain;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (w_empty) begin
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
        // Seed is registered on entry to LAUNCH so it is valid alongside samp_start.
        if (w_state_d == StLaunch) begin
            w_seed_d = {8'(w_row_d), 8'(w_col_d), w_rho_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_rho        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_row_max    <= '0;
            r_col_max    <= '0;
            r_idx        <= '0;
            r_seed       <= '0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_samp_abort <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_rho        <= w_rho_d;
            r_row        <= w_row_d;
            r_col        <= w_col_d;
            r_row_max    <= w_row_max_d;
            r_col_max    <= w_col_max_d;
            r_idx        <= w_idx_d;
            r_seed       <= w_seed_d;
            r_err        <= w_err_d;
            r_done       <= w_done_d;
            r_samp_abort <= i_abort;
        end
    end

    expand_a_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (i_abort),
        .i_push  (w_push),
        .i_data  (w_wr_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.out_valid = !w_empty;
    assign bus.out_coeff = w_head.coeff;
    assign bus.out_row   = w_head.row;
    assign bus.out_col   = w_head.col;
    assign bus.out_idx   = w_head.idx;
    assign bus.out_last  = bus.out_valid && (w_head.row == r_row_max)
                           && (w_head.col == r_col_max) && (w_head.idx == 8'hFF);

endmodule

// File: tb/tb_expand_a_stream.sv
// Bench for expand_a_stream: stub sampler, scoreboard of tagged coefficients, run table.
module tb_expand_a_stream;

    localparam int DEPTH = 4;
    localparam int QV    = 8380417;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   mode  = 2'd0;
    logic [255:0] rho;
    logic         busy, done, err;

    expand_a_stream_if bus ();

    expand_a_stream #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start),
        .i_abort (abort),
        .i_mode  (mode),
        .i_rho   (rho),
        .o_busy  (busy),
        .o_done  (done),
        .o_err   (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [22:0] coeff;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [7:0]  idx;
        logic        last;
    } exp_t;

    typedef struct {
        int mode;
        int k;
        int l;
        int rdy;
        int vld;
        int bad;
        bit exp_err;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    int   ready_pct = 100, valid_pct = 100, bad_idx = -1;
    int   exp_k = 4, exp_l = 4;
    int   walk_r = 0, walk_s = 0, cur_r = 0, cur_s = 0, st_idx = 0;
    bit   st_active = 1'b0;
    int   launches = 0, pops = 0, dones = 0, lasts = 0;
    bit   stall_prev = 1'b0;
    exp_t stall_head;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [22:0] stub_coeff();
        if (st_idx == bad_idx && cur_r == 0 && cur_s == 0) return 23'(QV);
        return 23'(st_idx + 1000 * (cur_r * 16 + cur_s));
    endfunction

    // Stub sampler and output consumer, driven just after the active edge.
    always @(posedge clk) begin
        #1;
        bus.samp_valid = st_active && ($urandom_range(99) < valid_pct);
        bus.samp_coeff = stub_coeff();
        bus.out_ready  = ($urandom_range(99) < ready_pct);
    end

    // Monitor: decides what the next active edge will do and checks it against the model.
    always @(negedge clk) begin
        exp_t h;
        exp_t e;
        if (rst_n && mon_en) begin
            h = {bus.out_coeff, bus.out_row, bus.out_col, bus.out_idx, bus.out_last};
            check("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
            if (stall_prev && bus.out_valid) check("head_hold", 64'(h), 64'(stall_head));
            if (sb.size() == DEPTH) check("ready_full", 64'(bus.samp_ready), 64'd0);
            if (bus.samp_start) begin
                check("seed_rho", 64'(bus.samp_seed[255:0] == rho), 64'd1);
                check("seed_s", 64'(bus.samp_seed[263:256]), 64'(walk_s));
                check("seed_r", 64'(bus.samp_seed[271:264]), 64'(walk_r));
                cur_r = walk_r;
                cur_s = walk_s;
                st_idx = 0;
                st_active = 1'b1;
                launches++;
                walk_s++;
                if (walk_s == exp_l) begin
                    walk_s = 0;
                    walk_r++;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("pop_unexpected", 64'(h), 64'd0);
                end else begin
                    check("pop", 64'(h), 64'(sb.pop_front()));
                end
                pops++;
                if (h.last) lasts++;
            end
            if (abort) begin
                sb.delete();
                st_active = 1'b0;
            end else if (bus.samp_valid && bus.samp_ready) begin
                e.coeff = stub_coeff();
                e.row   = 3'(cur_r);
                e.col   = 3'(cur_s);
                e.idx   = 8'(st_idx);
                e.last  = (cur_r == exp_k - 1) && (cur_s == exp_l - 1) && (st_idx == 255);
                sb.push_back(e);
                st_idx++;
                if (st_idx == 256) st_active = 1'b0;
            end
            stall_prev = bus.out_valid && !bus.out_ready && !abort;
            stall_head = h;
            if (done) begin
                dones++;
                check("busy_with_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_samp_start", 64'(bus.samp_start), 64'd0);
        check("rst_samp_abort", 64'(bus.samp_abort), 64'd0);
        check("rst_samp_ready", 64'(bus.samp_ready), 64'd0);
        check("rst_seed", 64'(|bus.samp_seed), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_head", 64'({bus.out_coeff, bus.out_row, bus.out_col, bus.out_idx}), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
    endtask

    task automatic arm(input vec_t v);
        ready_pct = v.rdy;
        valid_pct = v.vld;
        bad_idx   = v.bad;
        exp_k     = v.k;
        exp_l     = v.l;
        walk_r    = 0;
        walk_s    = 0;
        launches  = 0;
        pops      = 0;
        dones     = 0;
        lasts     = 0;
    endtask

    task automatic pulse_start(input int m);
        @(posedge clk);
        #1;
        mode  = 2'(m);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        arm(v);
        pulse_start(v.mode);
        ok = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(ok), 64'd1);
        @(negedge clk);
        check("launches", 64'(launches), 64'(v.k * v.l));
        check("pops", 64'(pops), 64'(v.k * v.l * 256));
        check("last_count", 64'(lasts), 64'd1);
        check("done_count", 64'(dones), 64'd1);
        check("err_end", 64'(err), 64'(v.exp_err));
        check("busy_end", 64'(busy), 64'd0);
        check("last_seed_s", 64'(bus.samp_seed[263:256]), 64'(v.l - 1));
        check("last_seed_r", 64'(bus.samp_seed[271:264]), 64'(v.k - 1));
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    vec_t vecs[4];

    initial begin
        bit found;
        vecs[0] = '{mode: 0, k: 4, l: 4, rdy: 100, vld: 100, bad: -1, exp_err: 1'b0};
        vecs[1] = '{mode: 2, k: 8, l: 7, rdy: 50,  vld: 60,  bad: -1, exp_err: 1'b0};
        vecs[2] = '{mode: 1, k: 6, l: 5, rdy: 100, vld: 70,  bad: -1, exp_err: 1'b0};
        vecs[3] = '{mode: 0, k: 4, l: 4, rdy: 40,  vld: 100, bad: 5,  exp_err: 1'b1};
        for (int i = 0; i < 32; i++) rho[8*i +: 8] = 8'(i);

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Invalid mode: error, no launch, stays idle.
        arm(vecs[0]);
        pulse_start(3);
        @(negedge clk);
        check("mode3_err", 64'(err), 64'd1);
        check("mode3_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("mode3_no_launch", 64'(launches), 64'd0);
        check("mode3_busy_late", 64'(busy), 64'd0);

        // Valid start clears err; abort at poly (1,2) idx 100.
        arm(vecs[0]);
        pulse_start(0);
        @(negedge clk);
        check("start_clears_err", 64'(err), 64'd0);
        check("start_busy", 64'(busy), 64'd1);
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (st_active && cur_r == 1 && cur_s == 2 && st_idx == 100) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_point_reached", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_pulse", 64'(bus.samp_abort), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("abort_pulse_once", 64'(bus.samp_abort), 64'd0);
        repeat (10) @(negedge clk);
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_launches", 64'(launches), 64'd7);
        check("abort_err_kept", 64'(err), 64'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of a run.
        arm(vecs[0]);
        pulse_start(0);
        repeat (300) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        st_active  = 1'b0;
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
